adsr_envelope: RTL and testbench
================================

ADSR_ENVELOPE -- requirements
Module: adsr_envelope

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the signed sample width in and out.
REQ-002 SHALL have parameter ENV_WIDTH, default 16, the unsigned envelope level and step width.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_active_high  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sample_tick  input  1  one-cycle strobe at the audio sample rate; the envelope advances only on cycles where it is high.
REQ-006 SHALL have port gate  input  1  note-on level (1 = key held).
REQ-007 SHALL have ports attack_step, decay_step, release_step  input  ENV_WIDTH  per-tick level increment or decrement.
REQ-008 SHALL have port sustain_level  input  ENV_WIDTH  hold level for SUSTAIN.
REQ-009 SHALL have port sample_in  input  DATA_WIDTH signed  the DDS sine output.
REQ-010 SHALL have port sample_out  output  DATA_WIDTH signed  the amplitude-shaped sample.
REQ-011 SHALL have port env_level  output  ENV_WIDTH  the current envelope level.
REQ-012 SHALL have port env_state  output  3  the current state encoding.
REQ-013 SHALL have port busy  output  1  high whenever env_state != IDLE.

Function
REQ-014 SHALL implement the states IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3 and RELEASE=4; all other encodings SHALL be unreachable.
REQ-015 SHALL sample gate into gate_q only on ticks; rise = gate & ~gate_q and fall = ~gate & gate_q, evaluated on ticks only.
REQ-016 SHALL hold state, level and gate_q unchanged on cycles without a tick.
REQ-017 SHALL, on a tick with rise from any state, enter ATTACK and keep the current level (no drop to 0); rise has the highest priority.
REQ-018 SHALL, on a tick with fall while in ATTACK, DECAY or SUSTAIN, enter RELEASE with the level unchanged that tick.
REQ-019 SHALL, in ATTACK, perform level += attack_step; if the sum is >= ENV_MAX (all ones, with ENV_WIDTH+1-bit compare), set level = ENV_MAX and enter DECAY on the same tick.
REQ-020 SHALL, in ATTACK with attack_step = 0, hold the level and stay in ATTACK.
REQ-021 SHALL, in DECAY, clamp level to sustain_level and enter SUSTAIN if level <= sustain_level + decay_step (no underflow); otherwise level -= decay_step.
REQ-022 SHALL, in SUSTAIN, set level = sustain_level on every tick, tracking live changes.
REQ-023 SHALL, in RELEASE, set level = 0 and enter IDLE if level <= release_step; otherwise level -= release_step; with release_step = 0 the level holds.
REQ-024 SHALL, in IDLE without rise, hold level = 0.
REQ-025 SHALL register sample_out every clk (not gated by the tick) as (sample_in * signed{1'b0, env_level}) >>> ENV_WIDTH, using a full 33-bit signed product and an arithmetic shift (floor); the latency is 1 cycle from sample_in and from env_level.
REQ-026 SHALL never overflow sample_out: with env_level = 0xFFFF, an input of -32768 SHALL give -32768 and an input of 32767 SHALL give 32766.
REQ-027 SHALL drive env_level, env_state and busy directly from registers.

Reset
REQ-028 SHALL, on reset, set state = IDLE, level = 0, gate_q = 0, sample_out = 0 and busy = 0 immediately, without waiting for clk.
REQ-029 SHALL abandon any phase when reset is asserted mid-envelope, and SHALL need a fresh rise after release (gate held high through reset counts as a rise on the first tick).

Structure
REQ-030 SHALL place env_state_t (3-bit enum) and ENV_MAX in shared package tracker_pkg.
REQ-031 SHALL place the registered multiply of REQ-025 in sub-module env_vca; the FSM and level arithmetic SHALL stay in adsr_envelope.

Verification
REQ-032 SHALL cover: tick every 4 clks, attack_step = 0x4000, gate 0->1 -> level 0x4000, 0x8000 and 0xC000 on ticks 1-3, then 0xFFFF and DECAY on tick 4.
REQ-033 SHALL cover: decay_step = 0x3000, sustain = 0x8000 from 0xFFFF -> 0xCFFF, 0x9FFF, then 0x8000 with SUSTAIN; changing sustain to 0x2000 -> level 0x2000 on the next tick.
REQ-034 SHALL cover: gate fall in SUSTAIN at 0x2000 with release_step = 0x0800 -> RELEASE, then 0x1800, 0x1000, 0x0800, then 0 with IDLE and busy = 0.
REQ-035 SHALL cover: gate re-rise during RELEASE at level 0x1000 -> ATTACK starting from 0x1000 on that tick, with no step to 0.
REQ-036 SHALL cover: env_level = 0xFFFF with sample_in 32767 / -32768 -> sample_out 32766 / -32768 one cycle later; env_level = 0x8000 with sample_in 1000 -> 500.
REQ-037 SHALL cover: reset asserted mid-ATTACK between clock edges -> all outputs 0 and IDLE before the next clk edge; gate high at deassertion -> ATTACK on the first tick.

Source files
------------

// File: rtl/tracker_pkg.sv
// rtl/tracker_pkg.sv - shared envelope state encoding and level constants
package tracker_pkg;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    // All-ones full-scale level; users slice the low ENV_WIDTH bits.
    localparam logic [31:0] ENV_MAX = 32'hFFFF_FFFF;

    function automatic logic env_is_busy(input env_state_t s);
        return s != ENV_IDLE;
    endfunction

endpackage

// File: rtl/env_vca.sv
// rtl/env_vca.sv - registered amplitude multiply of a signed sample by the envelope
module env_vca #(
    parameter int DATA_WIDTH = 16,
    parameter int ENV_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_active_high,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    input  logic        [ENV_WIDTH-1:0]  env_level,
    output logic signed [DATA_WIDTH-1:0] sample_out
);

    localparam int PROD_WIDTH = DATA_WIDTH + ENV_WIDTH + 1;

    logic signed [PROD_WIDTH-1:0] sample_ext;
    logic signed [PROD_WIDTH-1:0] env_ext;
    logic signed [PROD_WIDTH-1:0] product;
    logic signed [DATA_WIDTH-1:0] sample_d;
    logic signed [DATA_WIDTH-1:0] sample_q;
    logic                         unused_prod_msb;

    // Full-width signed product; taking bits above ENV_WIDTH is a floor shift.
    // The top product bit never differs from the kept sign bit because the
    // envelope is strictly below 1.0, so the result cannot overflow.
    always_comb begin
        sample_ext = signed'({{(ENV_WIDTH + 1){sample_in[DATA_WIDTH-1]}}, sample_in});
        env_ext    = signed'({{DATA_WIDTH{1'b0}}, 1'b0, env_level});
        product    = sample_ext * env_ext;
        sample_d   = product[DATA_WIDTH+ENV_WIDTH-1:ENV_WIDTH];
    end

    assign unused_prod_msb = product[PROD_WIDTH-1];

    // Output register runs every clock, independent of the sample tick.
    always_ff @(posedge clk or posedge rst_active_high) begin
        if (rst_active_high) begin
            sample_q <= '0;
        end else begin
            sample_q <= sample_d;
        end
    end

    assign sample_out = sample_q;

endmodule

// File: rtl/adsr_envelope.sv
// rtl/adsr_envelope.sv - tick-driven ADSR envelope generator with output VCA
module adsr_envelope #(
    parameter int DATA_WIDTH = 16,
    parameter int ENV_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_active_high,
    input  logic                         sample_tick,
    input  logic                         gate,
    input  logic        [ENV_WIDTH-1:0]  attack_step,
    input  logic        [ENV_WIDTH-1:0]  decay_step,
    input  logic        [ENV_WIDTH-1:0]  release_step,
    input  logic        [ENV_WIDTH-1:0]  sustain_level,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    output logic signed [DATA_WIDTH-1:0] sample_out,
    output logic        [ENV_WIDTH-1:0]  env_level,
    output logic        [2:0]            env_state,
    output logic                         busy
);

    import tracker_pkg::*;

    localparam logic [ENV_WIDTH-1:0] LEVEL_MAX = ENV_MAX[ENV_WIDTH-1:0];

    env_state_t             state_q, state_d;
    logic [ENV_WIDTH-1:0]   level_q, level_d;
    logic                   gate_q, gate_d;
    logic                   busy_q;
    logic                   rise, fall;
    logic [ENV_WIDTH:0]     attack_sum;
    logic [ENV_WIDTH:0]     decay_floor;

    // State, level, gate history and busy flag; reset abandons any phase.
    always_ff @(posedge clk or posedge rst_active_high) begin
        if (rst_active_high) begin
            state_q <= ENV_IDLE;
            level_q <= '0;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            gate_q  <= gate_d;
            busy_q  <= env_is_busy(state_d);
        end
    end

    // Next state and level; nothing moves on cycles without a tick.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        gate_d      = gate_q;
        rise        = 1'b0;
        fall        = 1'b0;
        attack_sum  = {1'b0, level_q} + {1'b0, attack_step};
        decay_floor = {1'b0, sustain_level} + {1'b0, decay_step};
        if (sample_tick) begin
            gate_d = gate;
            rise   = gate & ~gate_q;
            fall   = ~gate & gate_q;
            if (rise) begin
                // Retrigger keeps the current level to avoid a click.
                state_d = ENV_ATTACK;
            end else begin
                case (state_q)
                    ENV_IDLE: begin
                        level_d = '0;
                    end
                    ENV_ATTACK: begin
                        if (fall) begin
                            state_d = ENV_RELEASE;
                        end else if (attack_step == '0) begin
                            level_d = level_q;
                        end else if (attack_sum >= {1'b0, LEVEL_MAX}) begin
                            level_d = LEVEL_MAX;
                            state_d = ENV_DECAY;
                        end else begin
                            level_d = attack_sum[ENV_WIDTH-1:0];
                        end
                    end
                    ENV_DECAY: begin
                        if (fall) begin
                            state_d = ENV_RELEASE;
                        end else if ({1'b0, level_q} <= decay_floor) begin
                            level_d = sustain_level;
                            state_d = ENV_SUSTAIN;
                        end else begin
                            level_d = level_q - decay_step;
                        end
                    end
                    ENV_SUSTAIN: begin
                        if (fall) begin
                            state_d = ENV_RELEASE;
                        end else begin
                            level_d = sustain_level;
                        end
                    end
                    ENV_RELEASE: begin
                        if (level_q <= release_step) begin
                            level_d = '0;
                            state_d = ENV_IDLE;
                        end else begin
                            level_d = level_q - release_step;
                        end
                    end
                    default: begin
                        level_d = '0;
                        state_d = ENV_IDLE;
                    end
                endcase
            end
        end
    end

    // Status outputs come straight from registers.
    always_comb begin
        env_state = state_q;
        env_level = level_q;
        busy      = busy_q;
    end

    env_vca #(
        .DATA_WIDTH(DATA_WIDTH),
        .ENV_WIDTH (ENV_WIDTH)
    ) u_vca (
        .clk            (clk),
        .rst_active_high(rst_active_high),
        .sample_in      (sample_in),
        .env_level      (level_q),
        .sample_out     (sample_out)
    );

endmodule

// File: tb/tb_adsr_envelope.sv
// tb/tb_adsr_envelope.sv - directed scoreboard bench for adsr_envelope
module tb_adsr_envelope;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ATTACK  = 3'd1;
    localparam logic [2:0] S_DECAY   = 3'd2;
    localparam logic [2:0] S_SUSTAIN = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic               clk = 1'b0;
    logic               rst_active_high;
    logic               sample_tick;
    logic               gate;
    logic [15:0]        attack_step;
    logic [15:0]        decay_step;
    logic [15:0]        release_step;
    logic [15:0]        sustain_level;
    logic signed [15:0] sample_in;
    logic signed [15:0] sample_out;
    logic [15:0]        env_level;
    logic [2:0]         env_state;
    logic               busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [15:0] level;
        logic [2:0]  state;
    } env_exp_t;

    env_exp_t env_q[$];
    int       vca_q[$];

    adsr_envelope #(.DATA_WIDTH(16), .ENV_WIDTH(16)) dut (
        .clk            (clk),
        .rst_active_high(rst_active_high),
        .sample_tick    (sample_tick),
        .gate           (gate),
        .attack_step    (attack_step),
        .decay_step     (decay_step),
        .release_step   (release_step),
        .sustain_level  (sustain_level),
        .sample_in      (sample_in),
        .sample_out     (sample_out),
        .env_level      (env_level),
        .env_state      (env_state),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One tick, compared one clock later; level must then hold for three idle clocks.
    task automatic env_tick(input string tag, input logic [15:0] lvl, input logic [2:0] st);
        env_exp_t e;
        e.tag   = tag;
        e.level = lvl;
        e.state = st;
        env_q.push_back(e);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        e = env_q.pop_front();
        check({e.tag, ".level"}, {16'h0, env_level}, {16'h0, e.level});
        check({e.tag, ".state"}, {29'h0, env_state}, {29'h0, e.state});
        check({e.tag, ".busy"}, {31'h0, busy}, {31'h0, (e.state != S_IDLE)});
        repeat (3) @(negedge clk);
        check({e.tag, ".hold"}, {16'h0, env_level}, {16'h0, e.level});
    endtask

    task automatic vca(input string tag, input logic signed [15:0] din, input int exp);
        sample_in = din;
        vca_q.push_back(exp);
        @(negedge clk);
        check(tag, int'(sample_out), vca_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_active_high = 1'b1;
        sample_tick     = 1'b0;
        gate            = 1'b0;
        attack_step     = 16'h0;
        decay_step      = 16'h0;
        release_step    = 16'h0;
        sustain_level   = 16'h0;
        sample_in       = 16'sd0;
        repeat (3) @(negedge clk);
        check("reset.level", {16'h0, env_level}, 32'h0);
        check("reset.state", {29'h0, env_state}, 32'h0);
        check("reset.busy", {31'h0, busy}, 32'h0);
        check("reset.sample", int'(sample_out), 0);

        rst_active_high = 1'b0;
        attack_step     = 16'h4000;
        decay_step      = 16'h3000;
        sustain_level   = 16'h8000;
        release_step    = 16'h0800;
        @(negedge clk);
        env_tick("idle", 16'h0000, S_IDLE);

        // First note: attack, decay, sustain, release to idle.
        gate = 1'b1;
        env_tick("rise", 16'h0000, S_ATTACK);
        env_tick("atk1", 16'h4000, S_ATTACK);
        env_tick("atk2", 16'h8000, S_ATTACK);
        vca("vca_half", 16'sd1000, 500);
        env_tick("atk3", 16'hC000, S_ATTACK);
        env_tick("atk4", 16'hFFFF, S_DECAY);
        vca("vca_pos", 16'sd32767, 32766);
        vca("vca_neg", -16'sd32768, -32768);
        sample_in = 16'sd0;
        env_tick("dec1", 16'hCFFF, S_DECAY);
        env_tick("dec2", 16'h9FFF, S_DECAY);
        env_tick("dec3", 16'h8000, S_SUSTAIN);
        sustain_level = 16'h2000;
        env_tick("sus_track", 16'h2000, S_SUSTAIN);
        gate = 1'b0;
        env_tick("fall", 16'h2000, S_RELEASE);
        env_tick("rel1", 16'h1800, S_RELEASE);
        env_tick("rel2", 16'h1000, S_RELEASE);
        env_tick("rel3", 16'h0800, S_RELEASE);
        env_tick("rel4", 16'h0000, S_IDLE);
        env_tick("idle2", 16'h0000, S_IDLE);

        // Second note: big decay step, then retrigger during release.
        gate = 1'b1;
        env_tick("rise2", 16'h0000, S_ATTACK);
        env_tick("b_atk1", 16'h4000, S_ATTACK);
        env_tick("b_atk2", 16'h8000, S_ATTACK);
        env_tick("b_atk3", 16'hC000, S_ATTACK);
        env_tick("b_atk4", 16'hFFFF, S_DECAY);
        decay_step = 16'hFFFF;
        env_tick("dec_big", 16'h2000, S_SUSTAIN);
        gate = 1'b0;
        env_tick("fall2", 16'h2000, S_RELEASE);
        env_tick("b_rel1", 16'h1800, S_RELEASE);
        env_tick("b_rel2", 16'h1000, S_RELEASE);
        gate = 1'b1;
        env_tick("rerise", 16'h1000, S_ATTACK);
        env_tick("atk_from", 16'h5000, S_ATTACK);
        attack_step = 16'h0000;
        env_tick("atk_zero", 16'h5000, S_ATTACK);
        vca("vca_mid", 16'sd16384, 5120);

        // Reset between clock edges while in attack with the gate held.
        attack_step = 16'hC000;
        @(posedge clk);
        #2;
        rst_active_high = 1'b1;
        #1;
        check("arst.level", {16'h0, env_level}, 32'h0);
        check("arst.state", {29'h0, env_state}, 32'h0);
        check("arst.busy", {31'h0, busy}, 32'h0);
        check("arst.sample", int'(sample_out), 0);
        @(negedge clk);
        @(negedge clk);
        rst_active_high = 1'b0;
        env_tick("rst_rise", 16'h0000, S_ATTACK);
        env_tick("sat1", 16'hC000, S_ATTACK);
        env_tick("sat2", 16'hFFFF, S_DECAY);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
